window_ram_arbiter: RTL and testbench
=====================================

// Module: window_ram_arbiter
// PURPOSE
//  Shares the single-port 64-entry sliding-window RAM among three requesters:
//  loader (ID0, writes), match engine (ID1, reads), window-slide unit (ID2, read/write).
//  Sits between the RAM control FSM's client units and the window RAM.
//  Round-robin, burst-granted, with forced re-arbitration after MAX_BURST beats.
// PARAMETERS
//  ADDR_W     6   window RAM address width (64 entries)
//  DATA_W     8   window RAM data width
//  MAX_BURST  64  max beats per grant before preemption, if another requester waits
// PORTS
//  Clk        in   1              clock, rising edge
//  Rst        in   1              asynchronous, active-high reset
//  req        in   3              per-requester request; held high until granted
//  we         in   3              per-requester write enable (valid with req)
//  addr       in   3*ADDR_W       per-requester address; slice i = requester i
//  wdata      in   3*DATA_W       per-requester write data; slice i = requester i
//  gnt        out  3              one-hot grant, registered
//  rvalid     out  3              read data valid for requester i, registered
//  rdata      out  DATA_W         read data, shared; qualified by rvalid
//  owner      out  2              ID of current grant holder (3 = none)
//  busy       out  1              high while any grant is held
//  ram_en     out  1              RAM enable
//  ram_we     out  1              RAM write enable
//  ram_addr   out  ADDR_W         RAM address
//  ram_wdata  out  DATA_W         RAM write data
//  ram_rdata  in   DATA_W         RAM read data, 1-cycle read latency
// BEHAVIOUR
//  Reset values (async): gnt=0, rvalid=0, owner=3, busy=0, beat_cnt=0,
//   rr_ptr=0, state=S_IDLE. rdata and ram_* are combinational and therefore 0
//   while reset is held.
//  States are one-hot: S_IDLE, S_GRANT.
//  S_IDLE:
//   - If req!=0: pick the first requester with req=1, scanning rr_ptr, rr_ptr+1, ... mod 3.
//   - Next cycle: gnt[w]=1, owner=w, busy=1, beat_cnt=0; go to S_GRANT.
//   - Otherwise stay in S_IDLE.
//  S_GRANT, owner o:
//   - Beat = req[o]&gnt[o]. On a beat: ram_en=1, ram_we=we[o], ram_addr=addr[o],
//     ram_wdata=wdata[o], combinationally in the same cycle.
//   - No beat: ram_en=0 and ram_we=0.
//   - Read beat at cycle t: rvalid[o]=1 at t+1, rdata=ram_rdata.
//   - Write beat: no rvalid.
//  Release: req[o]=0 in S_GRANT -> next cycle gnt=0, owner=3, busy=0,
//   rr_ptr=(o+1) mod 3, go to S_IDLE.
//   - This leaves a minimum 1 dead cycle between owners.
//   - An rvalid from the last beat still fires.
//  Burst limit: beat_cnt (clog2(MAX_BURST) bits) increments per beat.
//   - Beat with beat_cnt==MAX_BURST-1 and another req[j]=1 (j!=o): preempt.
//     Same effect as release, rr_ptr=(o+1) mod 3. The preempted requester keeps req
//     high and rejoins arbitration.
//   - Beat with beat_cnt==MAX_BURST-1 and no other request: beat_cnt wraps to 0,
//     grant is kept.
//  Simultaneous events:
//   - req[o] drops on the preempt cycle: treated as release, no beat.
//   - New requests arriving during S_GRANT wait; only the owner's addr/wdata/we
//     are observed.
//  gnt is never multi-hot. ram_we=1 only on a beat of a requester with we=1.
//  Rst mid-burst: everything clears immediately and pending rvalid is dropped.
//   The requester must re-request after reset.
// STRUCTURE
//  Shared package window_ram_pkg:
//   - ADDR_W/DATA_W defaults
//   - requester IDs REQ_LD=0, REQ_MATCH=1, REQ_SLIDE=2, OWNER_NONE=3
//   - one-hot state constants S_IDLE, S_GRANT
//  Sub-module rr_pick: combinational 3-way round-robin picker
//   - inputs req[2:0], ptr[1:0]; outputs win[1:0], any.
//  Top holds the FSM, beat counter, rr_ptr, RAM mux and rvalid pipeline register.
// TESTING
//  1. Reset, req=3'b001 with we=1, addr 0..63 as 64 beats:
//     gnt=001 one cycle after req; 64 writes land in RAM; ID0 drops req -> gnt=0 next cycle, rr_ptr=1.
//  2. req=3'b111 from idle, rr_ptr=0, each requester does 2 beats and releases:
//     grants in order 001, 010, 100, with exactly 1 idle cycle between grants.
//  3. ID1 reads addr 5 (RAM holds 8'hA5):
//     rvalid=010 exactly 1 cycle after the beat, rdata=8'hA5; rvalid[0] and rvalid[2] stay 0.
//  4. ID0 holds req for 70 beats while ID2 requests at beat 10:
//     preempt after beat 64; gnt=100 two cycles later; ID0 regains grant after ID2 releases.
//  5. ID0 alone, 130 beats: no preemption; beat_cnt wraps twice; gnt stays 001.
//  6. Assert Rst mid-read-beat:
//     gnt, rvalid, busy, ram_en go 0 asynchronously; owner=3; after release, arbitration restarts at ID0.

Source files
------------

// File: rtl/window_ram_pkg.sv
// Shared definitions for the window RAM arbiter: default widths, requester IDs,
// the one-hot arbiter states and small ID helpers.
package window_ram_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 64;

  // Requester IDs; OWNER_NONE marks "no grant held".
  localparam logic [1:0] REQ_LD     = 2'd0;
  localparam logic [1:0] REQ_MATCH  = 2'd1;
  localparam logic [1:0] REQ_SLIDE  = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  // One-hot arbiter states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_GRANT = 2'b10
  } state_e;

  // Requester ID to one-hot grant vector; OWNER_NONE maps to no grant.
  function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
    logic [2:0] oh;
    case (id)
      REQ_LD:    oh = 3'b001;
      REQ_MATCH: oh = 3'b010;
      REQ_SLIDE: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Round-robin successor of a requester ID, (id + 1) mod 3.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    logic [1:0] nid;
    case (id)
      REQ_LD:    nid = REQ_MATCH;
      REQ_MATCH: nid = REQ_SLIDE;
      REQ_SLIDE: nid = REQ_LD;
      default:   nid = REQ_LD;
    endcase
    return nid;
  endfunction

endpackage

// File: rtl/window_ram_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: returns the first requester with req
// set, scanning ptr, ptr+1, ptr+2 (mod 3). 'any' flags that some request exists.
module rr_pick
  import window_ram_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  // Priority scan rotated by the round-robin pointer.
  always_comb begin
    win = REQ_LD;
    any = |req;
    case (ptr)
      REQ_MATCH: begin
        if (req[1])      win = REQ_MATCH;
        else if (req[2]) win = REQ_SLIDE;
        else if (req[0]) win = REQ_LD;
        else             win = REQ_LD;
      end
      REQ_SLIDE: begin
        if (req[2])      win = REQ_SLIDE;
        else if (req[0]) win = REQ_LD;
        else if (req[1]) win = REQ_MATCH;
        else             win = REQ_LD;
      end
      default: begin
        // REQ_LD, and the unused code 3 falls back to a plain 0,1,2 scan.
        if (req[0])      win = REQ_LD;
        else if (req[1]) win = REQ_MATCH;
        else if (req[2]) win = REQ_SLIDE;
        else             win = REQ_LD;
      end
    endcase
  end

endmodule

// File: rtl/window_ram_arbiter.sv
// Window RAM arbiter: shares the single-port sliding-window RAM between the
// loader, match engine and window-slide unit. Round-robin burst grants with a
// forced hand-over after MAX_BURST beats when someone else is waiting.
module window_ram_arbiter
  import window_ram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          owner,
  output logic                busy,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [2:0]         rvalid_q, rvalid_d;
  logic [1:0]         owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;

  // Owner-side view of the request bus.
  logic               own_req_s;
  logic               own_gnt_s;
  logic               own_we_s;
  logic [ADDR_W-1:0]  own_addr_s;
  logic [DATA_W-1:0]  own_wdata_s;
  logic               beat_s;
  logic               other_req_s;
  logic [1:0]         pick_win_s;
  logic               pick_any_s;

  rr_pick u_rr_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .win (pick_win_s),
    .any (pick_any_s)
  );

  // Select the current owner's request, write enable, address and data; other
  // requesters' buses are ignored while they wait.
  always_comb begin
    own_req_s   = 1'b0;
    own_gnt_s   = 1'b0;
    own_we_s    = 1'b0;
    own_addr_s  = {ADDR_W{1'b0}};
    own_wdata_s = {DATA_W{1'b0}};
    case (owner_q)
      REQ_LD: begin
        own_req_s   = req[0];
        own_gnt_s   = gnt_q[0];
        own_we_s    = we[0];
        own_addr_s  = addr[0 +: ADDR_W];
        own_wdata_s = wdata[0 +: DATA_W];
      end
      REQ_MATCH: begin
        own_req_s   = req[1];
        own_gnt_s   = gnt_q[1];
        own_we_s    = we[1];
        own_addr_s  = addr[ADDR_W +: ADDR_W];
        own_wdata_s = wdata[DATA_W +: DATA_W];
      end
      REQ_SLIDE: begin
        own_req_s   = req[2];
        own_gnt_s   = gnt_q[2];
        own_we_s    = we[2];
        own_addr_s  = addr[2*ADDR_W +: ADDR_W];
        own_wdata_s = wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        own_req_s   = 1'b0;
        own_gnt_s   = 1'b0;
      end
    endcase
    beat_s      = (state_q == S_GRANT) && own_req_s && own_gnt_s;
    other_req_s = |(req & ~id_to_onehot(owner_q));
  end

  // RAM port mux: driven straight from the owner's bus in the beat cycle, quiet
  // otherwise. Read data is only passed through while rvalid is up.
  always_comb begin
    ram_en = beat_s;
    ram_we = beat_s & own_we_s;
    if (beat_s) begin
      ram_addr  = own_addr_s;
      ram_wdata = own_wdata_s;
    end else begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = {DATA_W{1'b0}};
    end
    if (|rvalid_q) begin
      rdata = ram_rdata;
    end else begin
      rdata = {DATA_W{1'b0}};
    end
  end

  // Arbiter next state: grant from idle, count beats, release on req drop and
  // hand over at the burst limit only when another requester is waiting.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;

    // A read beat returns data one cycle later, even if the grant ends now.
    if (beat_s && !own_we_s) begin
      rvalid_d = id_to_onehot(owner_q);
    end else begin
      rvalid_d = 3'b000;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_any_s) begin
          state_d    = S_GRANT;
          gnt_d      = id_to_onehot(pick_win_s);
          owner_d    = pick_win_s;
          busy_d     = 1'b1;
          beat_cnt_d = {CNT_W{1'b0}};
        end else begin
          gnt_d   = 3'b000;
          owner_d = OWNER_NONE;
          busy_d  = 1'b0;
        end
      end
      S_GRANT: begin
        if (!beat_s || ((beat_cnt_q == LAST_BEAT) && other_req_s)) begin
          // Release by the owner, or preemption after the last beat of a burst.
          state_d    = S_IDLE;
          gnt_d      = 3'b000;
          owner_d    = OWNER_NONE;
          busy_d     = 1'b0;
          beat_cnt_d = {CNT_W{1'b0}};
          rr_ptr_d   = next_id(owner_q);
        end else if (beat_cnt_q == LAST_BEAT) begin
          // Nobody else waiting: keep the grant and start a new burst count.
          beat_cnt_d = {CNT_W{1'b0}};
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        gnt_d      = 3'b000;
        owner_d    = OWNER_NONE;
        busy_d     = 1'b0;
        beat_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbiter registers; reset also drops any rvalid still in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 3'b000;
      rvalid_q   <= 3'b000;
      owner_q    <= OWNER_NONE;
      busy_q     <= 1'b0;
      beat_cnt_q <= {CNT_W{1'b0}};
      rr_ptr_q   <= REQ_LD;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Registered outputs.
  always_comb begin
    gnt    = gnt_q;
    rvalid = rvalid_q;
    owner  = owner_q;
    busy   = busy_q;
  end

endmodule

// File: tb/tb_window_ram_arbiter.sv
// Self-checking bench for window_ram_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model
// (integer owner/pointer/beat count plus a reference memory image).
module tb_window_ram_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int MB = 64;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [2:0]      req = 3'b000;
  logic [2:0]      we = 3'b000;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic [1:0]      owner;
  logic            busy, ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram_mem [64] = '{default: 8'h00};
  logic [7:0] ref_mem [64] = '{default: 8'h00};

  // Behavioural model state: owner -1 means no grant.
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_cnt = 0;
  int         m_rv_id = -1;
  logic [7:0] m_rv_data = 8'h00;

  window_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .owner(owner), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 Clk = ~Clk;

  // Window RAM stand-in with one cycle of read latency.
  always @(posedge Clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_rv_id = -1;
  endtask

  function automatic logic [2:0] oh(input int id);
    return (id < 0) ? 3'b000 : 3'(1 << id);
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic check_outputs();
    logic beat;
    int   o;
    o = m_owner;
    beat = 1'b0;
    if (o >= 0) beat = req[o];
    chk("gnt", 32'(gnt), 32'(oh(o)));
    chk("owner", 32'(owner), (o < 0) ? 32'd3 : 32'(o));
    chk("busy", 32'(busy), (o < 0) ? 32'd0 : 32'd1);
    chk("rvalid", 32'(rvalid), 32'(oh(m_rv_id)));
    chk("rdata", 32'(rdata), (m_rv_id < 0) ? 32'd0 : 32'(m_rv_data));
    chk("ram_en", 32'(ram_en), 32'(beat));
    chk("ram_we", 32'(ram_we), (beat && we[o]) ? 32'd1 : 32'd0);
    if (beat) begin
      chk("ram_addr", 32'(ram_addr), 32'(addr[o*AW +: AW]));
      if (we[o]) chk("ram_wdata", 32'(ram_wdata), 32'(wdata[o*DW +: DW]));
    end
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_advance();
    int         o;
    int         a;
    logic       beat;
    logic [2:0] others;
    if (Rst) begin
      m_reset();
    end else begin
      o = m_owner;
      beat = 1'b0;
      if (o >= 0) beat = req[o];
      m_rv_id = -1;
      if (beat) begin
        a = int'(addr[o*AW +: AW]);
        if (we[o]) ref_mem[a] = wdata[o*DW +: DW];
        else begin
          m_rv_id   = o;
          m_rv_data = ref_mem[a];
        end
      end
      if (o >= 0) begin
        others = req;
        others[o] = 1'b0;
        if (!beat || (m_cnt == MB - 1 && others != 3'b000)) begin
          m_owner = -1;
          m_ptr   = (o + 1) % 3;
        end else if (m_cnt == MB - 1) m_cnt = 0;
        else m_cnt++;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 3]) begin
            m_owner = (m_ptr + k) % 3;
            m_cnt   = 0;
          end
        end
      end
    end
  endtask

  // One cycle: check at posedge+2, advance model, end at the next posedge+1.
  task automatic tick();
    #1;
    check_outputs();
    model_advance();
    @(posedge Clk);
    #1;
  endtask

  // Drive one requester's bus; the others get random values that must be ignored.
  task automatic drive(input int id, input logic w, input int a, input int d);
    we    = 3'($urandom);
    addr  = 18'($urandom);
    wdata = 24'($urandom);
    we[id] = w;
    addr[id*AW +: AW]  = AW'(a);
    wdata[id*DW +: DW] = DW'(d);
  endtask

  initial begin
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    Rst = 1'b0;

    // 1. Loader writes addresses 0..63 in one burst.
    req = 3'b001;
    drive(0, 1'b1, 0, 8'hA0);
    tick();
    chk("t1_gnt_first", 32'(gnt), 32'h1);
    for (int i = 0; i < 64; i++) begin
      drive(0, 1'b1, i, i ^ 8'hA0);
      tick();
    end
    chk("t1_gnt_burst", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();
    chk("t1_gnt_release", 32'(gnt), 32'h0);
    for (int i = 0; i < 64; i++) chk("t1_ram", 32'(ram_mem[i]), 32'(i ^ 8'hA0));
    // Pointer moved to ID1: with ID0 and ID1 both asking, ID1 wins.
    req = 3'b011;
    drive(1, 1'b0, 7, 0);
    tick();
    chk("t1_ptr", 32'(gnt), 32'h2);
    tick();
    req = 3'b001;
    tick();
    tick();
    chk("t1_ld_back", 32'(gnt), 32'h1);
    drive(0, 1'b0, 3, 0);
    tick();
    req = 3'b000;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;

    // 2. All three request from idle: 001, 010, 100 with one idle cycle between.
    req = 3'b111;
    for (int g = 0; g < 3; g++) begin
      drive(g, 1'($urandom), g + 10, 8'h11 * g);
      tick();
      chk("t2_gnt", 32'(gnt), 32'(oh(g)));
      tick();
      tick();
      req[g] = 1'b0;
      tick();
      chk("t2_idle", 32'(gnt), 32'h0);
    end

    // 3. Match engine reads address 5.
    req = 3'b010;
    drive(1, 1'b0, 5, 0);
    tick();
    chk("t3_gnt", 32'(gnt), 32'h2);
    tick();
    chk("t3_rvalid", 32'(rvalid), 32'h2);
    chk("t3_rdata", 32'(rdata), 32'hA5);
    req = 3'b000;
    tick();
    chk("t3_rvalid_off", 32'(rvalid), 32'h0);

    // 4. Loader holds req for 70 beats, slide unit asks at beat 10.
    req = 3'b001;
    drive(0, 1'b0, 0, 0);
    tick();
    for (int b = 1; b <= 64; b++) begin
      if (b == 10) req[2] = 1'b1;
      drive(0, 1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
      tick();
    end
    chk("t4_preempt", 32'(gnt), 32'h0);
    tick();
    chk("t4_slide", 32'(gnt), 32'h4);
    for (int b = 0; b < 3; b++) begin
      drive(2, 1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
      tick();
    end
    req = 3'b001;
    tick();
    tick();
    chk("t4_regain", 32'(gnt), 32'h1);
    for (int b = 0; b < 6; b++) begin
      drive(0, 1'b0, b, 0);
      tick();
    end
    req = 3'b000;
    tick();

    // 5. Loader alone for 130 beats: counter wraps, no preemption.
    req = 3'b001;
    tick();
    for (int b = 0; b < 130; b++) begin
      drive(0, 1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
      tick();
    end
    chk("t5_keep", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();

    // 6. Reset in the middle of a read beat.
    req = 3'b010;
    drive(1, 1'b0, 9, 0);
    tick();
    #1;
    chk("t6_beat", 32'(ram_en), 32'h1);
    #1;
    Rst = 1'b1;
    #1;
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_ram_en", 32'(ram_en), 32'h0);
    chk("t6_owner", 32'(owner), 32'h3);
    m_reset();
    @(posedge Clk);
    #1;
    chk("t6_rvalid", 32'(rvalid), 32'h0);
    Rst = 1'b0;
    req = 3'b111;
    tick();
    chk("t6_restart", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();
    tick();

    // Randomized traffic: short bursts, then sticky owners that hit the limit.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        we    = 3'($urandom);
        addr  = 18'($urandom);
        wdata = 24'($urandom);
        for (int i = 0; i < 3; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
        if (m_owner >= 0 && $urandom_range(0, 99) < ((phase == 0) ? 15 : 1))
          req[m_owner] = 1'b0;
        tick();
      end
    end
    req = 3'b000;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
